// File: rtl/rv_fetch_unit_if.sv
// Fetch-unit bundle: instruction memory port, redirect input, decode handshake and counters.
// The master side belongs to rv_fetch_unit; the slave side belongs to memory, branch logic and decode.
interface rv_fetch_unit_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 23
);
    logic [XLEN-1:0]  imem_addr;
    logic             imem_req;
    logic [31:0]      imem_rdata;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output imem_addr, imem_req,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        output cycle_cnt, fetch_cnt
    );

    modport slave (
        input  imem_addr, imem_req,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        input  cycle_cnt, fetch_cnt
    );
endinterface

// File: rtl/rv_fetch_unit.sv
// Instruction fetch front end: PC, DEPTH-entry prefetch queue toward decode, redirect flush, counters.
// Fetched words appear at decode one cycle after fetch; fetching stalls only when the queue is full and decode is not popping.
module rv_fetch_unit #(
    parameter int unsigned      XLEN     = 64,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      CNT_W    = 23
) (
    input  logic               clk,
    input  logic               rst,
    rv_fetch_unit_if.master    bus
);
    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = AW + 1;
    localparam logic [31:0]   NOP  = 32'h0000_0013;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic             push;
    logic             pop;
    logic             head_vld;

    assign head_vld = (count_q != '0);
    assign pop      = head_vld && bus.inst_ready;
    // A pop frees a slot in the same cycle, so a full queue still streams at one per cycle.
    assign push     = !rst && !bus.redirect_valid && ((count_q != FULL) || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cycle_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            // A pop coinciding with a redirect is still a completed handshake.
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr  = fetch_pc_q;
    assign bus.imem_req   = push;
    assign bus.inst_valid = head_vld;
    assign bus.inst       = head_vld ? inst_mem_q[rd_ptr_q] : NOP;
    assign bus.inst_pc    = head_vld ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.fetch_cnt  = fetch_cnt_q;
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboarded bench: a main instance (RESET_PC 0, CNT_W 23) and a wrap instance (RESET_PC 2^64-8, CNT_W 4).
// Stimulus queues expected handshakes and probes; one negedge monitor performs every comparison.
module tb_rv_fetch_unit;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } probe_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    exp_t   exp_q[$];
    exp_t   exp_w[$];
    probe_t probe_q[$];

    rv_fetch_unit_if #(.XLEN(64), .CNT_W(23)) bm ();
    rv_fetch_unit_if #(.XLEN(64), .CNT_W(4))  bw ();

    rv_fetch_unit #(
        .XLEN(64), .DEPTH(4), .RESET_PC(64'h0), .CNT_W(23)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .bus (bm)
    );

    rv_fetch_unit #(
        .XLEN(64), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .CNT_W(4)
    ) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bw)
    );

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    assign bm.imem_rdata = memf(bm.imem_addr);
    assign bw.imem_rdata = memf(bw.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string n, input int s, input logic [63:0] e);
        probe_t p;
        p.name = n;
        p.sel  = s;
        p.exp  = e;
        probe_q.push_back(p);
    endtask

    task automatic expect_main(input logic [63:0] pc);
        exp_q.push_back({pc, memf(pc)});
    endtask

    task automatic expect_wrap(input logic [63:0] pc);
        exp_w.push_back({pc, memf(pc)});
    endtask

    always @(negedge clk) begin
        exp_t        e;
        probe_t      p;
        logic [63:0] act;
        if (bm.inst_valid && bm.inst_ready) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL main_hs unexpected handshake: got pc=%h inst=%h, required none", bm.inst_pc, bm.inst);
            end else begin
                e = exp_q.pop_front();
                if (bm.inst_pc !== e.pc || bm.inst !== e.ins) begin
                    n_err = n_err + 1;
                    $display("FAIL main_hs: got pc=%h inst=%h, required pc=%h inst=%h", bm.inst_pc, bm.inst, e.pc, e.ins);
                end
            end
        end
        if (bw.inst_valid && bw.inst_ready) begin
            n_cmp = n_cmp + 1;
            if (exp_w.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL wrap_hs unexpected handshake: got pc=%h inst=%h, required none", bw.inst_pc, bw.inst);
            end else begin
                e = exp_w.pop_front();
                if (bw.inst_pc !== e.pc || bw.inst !== e.ins) begin
                    n_err = n_err + 1;
                    $display("FAIL wrap_hs: got pc=%h inst=%h, required pc=%h inst=%h", bw.inst_pc, bw.inst, e.pc, e.ins);
                end
            end
        end
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.sel)
                0:  act = 64'(bm.inst_valid);
                1:  act = 64'(bm.imem_req);
                2:  act = bm.imem_addr;
                3:  act = 64'(bm.inst);
                4:  act = bm.inst_pc;
                5:  act = 64'(bm.cycle_cnt);
                6:  act = 64'(bm.fetch_cnt);
                7:  act = bw.imem_addr;
                8:  act = bw.inst_pc;
                9:  act = 64'(bw.cycle_cnt);
                10: act = 64'(exp_q.size());
                11: act = 64'(exp_w.size());
                default: act = 64'hDEAD_DEAD_DEAD_DEAD;
            endcase
            n_cmp = n_cmp + 1;
            if (act !== p.exp) begin
                n_err = n_err + 1;
                $display("FAIL %s: got %h, required %h", p.name, act, p.exp);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bm.inst_ready     = 1'b0;
        bm.redirect_valid = 1'b0;
        bm.redirect_pc    = '0;
        bw.inst_ready     = 1'b0;
        bw.redirect_valid = 1'b0;
        bw.redirect_pc    = '0;

        step();
        step();
        probe("rst_inst_valid", 0, 64'h0);
        probe("rst_imem_req",   1, 64'h0);
        probe("rst_imem_addr",  2, 64'h0);
        probe("rst_inst_nop",   3, 64'h13);
        probe("rst_inst_pc",    4, 64'h0);
        probe("rst_cycle_cnt",  5, 64'h0);
        probe("rst_fetch_cnt",  6, 64'h0);
        probe("rst_w_imem_addr", 7, 64'hFFFF_FFFF_FFFF_FFF8);
        probe("rst_w_inst_pc",  8, 64'h0);

        // Streaming from reset, with the wrap instance crossing 2^64.
        step();
        rst = 1'b0;
        bm.inst_ready = 1'b1;
        bw.inst_ready = 1'b1;
        probe("stream_imem_req", 1, 64'h1);
        for (int i = 0; i < 5; i++) expect_main(64'(4 * i));
        expect_wrap(64'hFFFF_FFFF_FFFF_FFF8);
        expect_wrap(64'hFFFF_FFFF_FFFF_FFFC);
        expect_wrap(64'h0);
        expect_wrap(64'h4);
        expect_wrap(64'h8);
        repeat (5) step();
        probe("stream_cycle_cnt", 5, 64'd5);
        probe("stream_fetch_cnt", 6, 64'd4);

        // Backpressure: queue fills to DEPTH and fetch stalls.
        step();
        bm.inst_ready = 1'b0;
        bw.inst_ready = 1'b0;
        repeat (9) step();
        probe("bp_imem_req",    1, 64'h0);
        probe("bp_imem_addr",   2, 64'h24);
        probe("bp_head_pc",     4, 64'h14);
        probe("bp_inst_valid",  0, 64'h1);
        probe("w_cycle_cnt_15", 9, 64'd15);

        step();
        bm.inst_ready = 1'b1;
        probe("w_cycle_cnt_wrap", 9, 64'd0);
        for (int i = 0; i < 5; i++) expect_main(64'(20 + 4 * i));
        repeat (4) step();

        // Redirect while full with a simultaneous pop.
        bm.redirect_valid = 1'b1;
        bm.redirect_pc    = 64'h203;
        probe("redir_full_imem_req", 1, 64'h0);
        probe("redir_full_fetch_cnt", 6, 64'd9);
        step();
        bm.redirect_valid = 1'b0;
        probe("redir_full_inst_valid", 0, 64'h0);
        probe("redir_full_imem_addr", 2, 64'h200);
        probe("redir_full_imem_req",  1, 64'h1);
        probe("redir_full_inst_nop",  3, 64'h13);
        probe("redir_full_inst_pc",   4, 64'h0);
        probe("redir_full_fetch_inc", 6, 64'd10);
        expect_main(64'h200);
        expect_main(64'h204);
        expect_main(64'h208);
        repeat (3) step();
        step();
        bm.inst_ready = 1'b0;
        repeat (2) step();

        // Redirect with three entries queued.
        bm.redirect_valid = 1'b1;
        bm.redirect_pc    = 64'h103;
        probe("redir3_imem_req", 1, 64'h0);
        probe("redir3_head_pc",  4, 64'h20C);
        step();
        bm.redirect_valid = 1'b0;
        probe("redir3_inst_valid", 0, 64'h0);
        probe("redir3_imem_addr",  2, 64'h100);
        step();
        probe("redir3_target_pc",    4, 64'h100);
        probe("redir3_target_valid", 0, 64'h1);
        bm.inst_ready = 1'b1;
        expect_main(64'h100);
        expect_main(64'h104);
        expect_main(64'h108);
        repeat (3) step();
        bm.inst_ready = 1'b0;
        repeat (3) step();

        // Reset for one cycle with a full queue.
        probe("full_head_pc", 4, 64'h10C);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bm.inst_ready = 1'b1;
        probe("mid_rst_inst_valid", 0, 64'h0);
        probe("mid_rst_inst_nop",   3, 64'h13);
        probe("mid_rst_inst_pc",    4, 64'h0);
        probe("mid_rst_cycle_cnt",  5, 64'h0);
        probe("mid_rst_fetch_cnt",  6, 64'h0);
        probe("mid_rst_imem_addr",  2, 64'h0);
        probe("mid_rst_imem_req",   1, 64'h1);
        probe("mid_rst_w_cycle",    9, 64'h0);
        probe("mid_rst_w_addr",     7, 64'hFFFF_FFFF_FFFF_FFF8);
        expect_main(64'h0);
        expect_main(64'h4);
        repeat (2) step();
        step();
        bm.inst_ready = 1'b0;
        step();
        step();
        probe("main_leftover", 10, 64'h0);
        probe("wrap_leftover", 11, 64'h0);
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
